// File: rtl/mips_pkg.sv
// Shared fetch/decode types: instruction width, default prefetch depth, queue entry layout.
package mips_pkg;

    localparam int INS_W            = 32;
    localparam int FQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [INS_W-1:0] pcp4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x 64-bit entry array for the prefetch queue.
// Latency: write lands at the clk edge, read is combinational.
// Backpressure: none here; the write enable is already qualified by the queue control.
module fetch_queue_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fq_entry_t     wdat,
    input  logic [AW-1:0] raddr,
    output fq_entry_t     rdat
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue of {ins, pcp4} pairs between fetch and decode, with single-cycle flush.
// Latency: one cycle enqueue-to-head; zero when empty if FETCH_QUEUE_BYPASS_EN is defined.
// Backpressure: enq_ready drops only when full (registered, independent of deq_ready).
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [INS_W-1:0]  enq_ins,
    input  logic [INS_W-1:0]  enq_pcp4,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [INS_W-1:0]  deq_ins,
    output logic [INS_W-1:0]  deq_pcp4,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    fq_entry_t     rd_dat;
    fq_entry_t     enq_dat;
    fq_entry_t     head;
    logic          byp;
    logic          byp_take;
    logic          enq_fire;
    logic          deq_fire;
    logic          store_enq;
    logic          store_deq;

    assign enq_dat = '{ins: enq_ins, pcp4: enq_pcp4};

    always_comb begin
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (cnt == '0) && enq_valid && !flush;
`endif
    end

    assign enq_ready = (cnt != FULL);
    assign deq_valid = ((cnt != '0) && !flush) || byp;
    assign head      = byp ? enq_dat : rd_dat;
    assign deq_ins   = deq_valid ? head.ins  : '0;
    assign deq_pcp4  = deq_valid ? head.pcp4 : '0;
    assign count     = cnt;

    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;
    // A bypassed pair that decode takes immediately never touches storage.
    assign byp_take  = byp && deq_ready;
    assign store_enq = enq_fire && !flush && !byp_take;
    assign store_deq = deq_fire && !byp_take;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (store_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (store_enq && !store_deq) begin
                cnt <= cnt + 1'b1;
            end else if (store_deq && !store_enq) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (store_enq),
        .waddr (wr_ptr),
        .wdat  (enq_dat),
        .raddr (rd_ptr),
        .rdat  (rd_dat)
    );

endmodule
